// File: rtl/lsu_br_pkg.sv
// Shared types for the load/store + branch unit: opcodes, FSM states and the
// opcode decode (access size, sign extension, op class).
package lsu_br_pkg;

   typedef enum logic [3:0] {
      LB, LH, LW, LBU, LHU, SB, SH, SW, BEQ, BNE, BLT, BGE, BLTU, BGEU
   } op_e;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

   typedef struct packed {
      logic  is_load;
      logic  is_store;
      logic  is_branch;
      logic  sign_ext;
      size_e size;
   } op_dec_t;

   function automatic op_dec_t decode_op(input op_e op);
      op_dec_t d;
      d.is_load   = 1'b0;
      d.is_store  = 1'b0;
      d.is_branch = 1'b0;
      d.sign_ext  = 1'b0;
      d.size      = SZ_B;
      case (op)
         LB:  begin d.is_load  = 1'b1; d.sign_ext = 1'b1; d.size = SZ_B; end
         LH:  begin d.is_load  = 1'b1; d.sign_ext = 1'b1; d.size = SZ_H; end
         LW:  begin d.is_load  = 1'b1; d.sign_ext = 1'b1; d.size = SZ_W; end
         LBU: begin d.is_load  = 1'b1; d.size = SZ_B; end
         LHU: begin d.is_load  = 1'b1; d.size = SZ_H; end
         SB:  begin d.is_store = 1'b1; d.size = SZ_B; end
         SH:  begin d.is_store = 1'b1; d.size = SZ_H; end
         SW:  begin d.is_store = 1'b1; d.size = SZ_W; end
         BEQ, BNE, BLT, BGE, BLTU, BGEU: d.is_branch = 1'b1;
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/lsu_br_cmp.sv
// Combinational branch condition evaluator: signed compares for BLT/BGE,
// unsigned for BLTU/BGEU.
module lsu_br_cmp
   import lsu_br_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  op_e             op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            taken
);

   logic signed [XLEN-1:0] rs1_s;
   logic signed [XLEN-1:0] rs2_s;

   assign rs1_s = $signed(rs1);
   assign rs2_s = $signed(rs2);

   always_comb begin
      taken = 1'b0;
      case (op)
         BEQ:  taken = (rs1 == rs2);
         BNE:  taken = (rs1 != rs2);
         BLT:  taken = (rs1_s <  rs2_s);
         BGE:  taken = (rs1_s >= rs2_s);
         BLTU: taken = (rs1 <  rs2);
         BGEU: taken = (rs1 >= rs2);
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/lsu_branch_unit.sv
// Single-issue load/store and branch-resolution unit with a REQ/WAIT memory FSM.
// Build macro LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning them.
module lsu_branch_unit
   import lsu_br_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  op_e               in_op,
   input  logic [XLEN-1:0]   in_rs1,
   input  logic [XLEN-1:0]   in_rs2,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic              flush,
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic              mem_we,
   output logic [XLEN/8-1:0] mem_be,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              res_valid,
   output logic [XLEN-1:0]   res_data,
   output logic [TAG_W-1:0]  res_tag,
   output logic              br_valid,
   output logic              br_taken,
   output logic [XLEN-1:0]   br_target,
   output logic              exc_valid,
   output logic [XLEN-1:0]   exc_addr
);

   localparam int BE_W  = XLEN / 8;
   localparam int OFF_W = $clog2(BE_W);

   function automatic logic [BE_W-1:0] size_mask(input size_e sz);
      logic [BE_W-1:0] m;
      m = '0;
      case (sz)
         SZ_B:    m[0]   = 1'b1;
         SZ_H:    m[1:0] = 2'b11;
         default: m[3:0] = 4'hF;
      endcase
      return m;
   endfunction

   function automatic logic [XLEN-1:0] store_lanes(input size_e sz, input logic [XLEN-1:0] v);
      case (sz)
         SZ_B:    return {(XLEN/8){v[7:0]}};
         SZ_H:    return {(XLEN/16){v[15:0]}};
         default: return {(XLEN/32){v[31:0]}};
      endcase
   endfunction

   // Shift the addressed lane down, then mask and optionally sign-fill above it.
   function automatic logic [XLEN-1:0] load_extract(input size_e sz, input logic sext,
                                                    input logic [XLEN-1:0] rdata,
                                                    input logic [OFF_W-1:0] off);
      logic [XLEN-1:0] s;
      logic [XLEN-1:0] mask;
      logic            msb;
      s = rdata >> {off, 3'b000};
      case (sz)
         SZ_B:    begin mask = XLEN'(8'hFF);         msb = s[7];  end
         SZ_H:    begin mask = XLEN'(16'hFFFF);      msb = s[15]; end
         default: begin mask = XLEN'(32'hFFFF_FFFF); msb = s[31]; end
      endcase
      s = s & mask;
      if (sext && msb) s = s | ~mask;
      return s;
   endfunction

   op_dec_t          dec;
   logic [XLEN-1:0]  eff_addr;
   logic [XLEN-1:0]  iss_addr;
   logic             misalign;
   logic             misalign_trap;
   logic             cmp_taken;

   state_e           state_q;
   state_e           state_nx;
   logic             accept;
   logic             issue;
   logic             trap;
   logic             br_fire;
   logic             capture;

   logic             mem_we_p1;
   logic [BE_W-1:0]  mem_be_p1;
   logic [XLEN-1:0]  mem_addr_p1;
   logic [XLEN-1:0]  mem_wdata_p1;
   size_e            ld_size_p1;
   logic             ld_sign_p1;
   logic [TAG_W-1:0] ld_tag_p1;
   logic             is_load_p1;
   logic             flush_seen_p1;
   logic             res_vld_p1;
   logic [XLEN-1:0]  res_data_p1;
   logic [TAG_W-1:0] res_tag_p1;
   logic             br_vld_p1;
   logic             br_taken_p1;
   logic [XLEN-1:0]  br_target_p1;
   logic             exc_vld_p1;
   logic [XLEN-1:0]  exc_addr_p1;

   assign dec      = decode_op(in_op);
   assign eff_addr = in_rs1 + in_imm;

   always_comb begin
      misalign = 1'b0;
      case (dec.size)
         SZ_H:    misalign = eff_addr[0];
         SZ_W:    misalign = |eff_addr[1:0];
         default: misalign = 1'b0;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign_trap = misalign;
   assign iss_addr      = eff_addr;
`else
   assign misalign_trap = 1'b0;
   always_comb begin
      iss_addr = eff_addr;
      if (misalign) begin
         iss_addr[0] = 1'b0;
         if (dec.size == SZ_W) iss_addr[1] = 1'b0;
      end
   end
`endif

   lsu_br_cmp #(.XLEN(XLEN)) u_cmp (
      .op    (in_op),
      .rs1   (in_rs1),
      .rs2   (in_rs2),
      .taken (cmp_taken)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nx;
   end

   // A flush on the accept cycle drops the branch/trap pulse due next cycle.
   always_comb begin
      state_nx = state_q;
      in_ready = (state_q == IDLE);
      mem_req  = (state_q == REQ);
      accept   = in_valid && (state_q == IDLE);
      issue    = 1'b0;
      trap     = 1'b0;
      br_fire  = 1'b0;
      capture  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (dec.is_branch) begin
                  br_fire = !flush;
               end else if (dec.is_load || dec.is_store) begin
                  if (misalign_trap) begin
                     trap = !flush;
                  end else begin
                     issue    = 1'b1;
                     state_nx = REQ;
                  end
               end
            end
         end
         REQ: begin
            if (flush) begin
               state_nx = IDLE;
            end else if (mem_gnt) begin
               if (is_load_p1 && mem_rvalid) begin
                  capture  = 1'b1;
                  state_nx = IDLE;
               end else if (is_load_p1) begin
                  state_nx = WAIT;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               capture  = !(flush || flush_seen_p1);
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Stage p1: request fields, writeback, branch and exception registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_we_p1     <= 1'b0;
         mem_be_p1     <= '0;
         mem_addr_p1   <= '0;
         mem_wdata_p1  <= '0;
         ld_size_p1    <= SZ_B;
         ld_sign_p1    <= 1'b0;
         ld_tag_p1     <= '0;
         is_load_p1    <= 1'b0;
         flush_seen_p1 <= 1'b0;
         res_vld_p1    <= 1'b0;
         res_data_p1   <= '0;
         res_tag_p1    <= '0;
         br_vld_p1     <= 1'b0;
         br_taken_p1   <= 1'b0;
         br_target_p1  <= '0;
         exc_vld_p1    <= 1'b0;
         exc_addr_p1   <= '0;
      end else begin
         res_vld_p1    <= capture;
         br_vld_p1     <= br_fire;
         exc_vld_p1    <= trap;
         flush_seen_p1 <= (state_nx == WAIT) && (flush_seen_p1 || ((state_q == WAIT) && flush));
         if (issue) begin
            mem_we_p1    <= dec.is_store;
            mem_be_p1    <= size_mask(dec.size) << iss_addr[OFF_W-1:0];
            mem_addr_p1  <= iss_addr;
            mem_wdata_p1 <= store_lanes(dec.size, in_rs2);
            ld_size_p1   <= dec.size;
            ld_sign_p1   <= dec.sign_ext;
            ld_tag_p1    <= in_tag;
            is_load_p1   <= dec.is_load;
         end
         if (capture) begin
            res_data_p1 <= load_extract(ld_size_p1, ld_sign_p1, mem_rdata, mem_addr_p1[OFF_W-1:0]);
            res_tag_p1  <= ld_tag_p1;
         end
         if (br_fire) begin
            br_taken_p1  <= cmp_taken;
            br_target_p1 <= in_pc + in_imm;
         end
         if (trap) exc_addr_p1 <= eff_addr;
      end
   end

   assign mem_we    = mem_we_p1;
   assign mem_be    = mem_be_p1;
   assign mem_addr  = mem_addr_p1;
   assign mem_wdata = mem_wdata_p1;
   assign res_valid = res_vld_p1;
   assign res_data  = res_data_p1;
   assign res_tag   = res_tag_p1;
   assign br_valid  = br_vld_p1;
   assign br_taken  = br_taken_p1;
   assign br_target = br_target_p1;
   assign exc_valid = exc_vld_p1;
   assign exc_addr  = exc_addr_p1;

endmodule
